fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch queue decoupling F2 from Decode: a DEPTH-entry circular buffer of {pc, instr, predict, br_hist}.
// Optional same-cycle empty-queue bypass from F2 to Decode when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter int              HIST_W    = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             f2_valid,
    output logic                             f2_ready,
    input  logic [XLEN-1:0]                  f2_pc,
    input  logic [XLEN-1:0]                  f2_instr,
    input  logic                             f2_predict,
    input  logic [HIST_W-1:0]                f2_br_hist,
    output logic                             d_valid,
    input  logic                             d_ready,
    output logic [XLEN-1:0]                  d_pc,
    output logic [XLEN-1:0]                  d_instr,
    output logic                             d_predict,
    output logic [HIST_W-1:0]                d_br_hist,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam int             EW      = 2 * XLEN + 1 + HIST_W;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          enq_s;
    logic          deq_s;
    logic          byp_s;
    logic          full_s;
    logic          empty_s;
    logic [EW-1:0] f2_ent_s;
    logic [EW-1:0] head_s;

    assign f2_ent_s = {f2_pc, f2_instr, f2_predict, f2_br_hist};
    assign head_s   = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Occupancy flags, bypass qualification and the Decode-side head view.
    always_comb begin
        empty_s  = (count_q == {CW{1'b0}});
        full_s   = (count_q >= DEPTH_C);
        f2_ready = !full_s;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp_s    = empty_s && f2_valid && !flush;
        d_valid  = !flush && (!empty_s || byp_s);
`else
        byp_s    = 1'b0;
        d_valid  = !empty_s;
`endif
        d_pc      = {XLEN{1'b0}};
        d_instr   = NOP_INSTR;
        d_predict = 1'b0;
        d_br_hist = {HIST_W{1'b0}};
        if (d_valid) begin
            if (byp_s) begin
                {d_pc, d_instr, d_predict, d_br_hist} = f2_ent_s;
            end else begin
                {d_pc, d_instr, d_predict, d_br_hist} = head_s;
            end
        end else begin
            d_pc = {XLEN{1'b0}};
        end
    end

    // Handshake qualification and next pointer/count state.
    always_comb begin
        // A consumed bypass entry never touches storage; an unconsumed one enqueues normally.
        enq_s    = f2_valid && f2_ready && !flush && !(byp_s && d_ready);
        deq_s    = d_valid && d_ready && !flush && !byp_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are left as-is on reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && enq_s) begin
            mem_q[wr_ptr_q] <= f2_ent_s;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model (honours FETCH_QUEUE_BYPASS_EN).
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        f2_valid;
    logic        f2_ready;
    logic [31:0] f2_pc;
    logic [31:0] f2_instr;
    logic        f2_predict;
    logic [1:0]  f2_br_hist;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_predict;
    logic [1:0]  d_br_hist;
    logic [2:0]  count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
        logic [1:0]  hist;
    } ent_t;

    ent_t mq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   byp_build;

    fetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .f2_valid   (f2_valid),
        .f2_ready   (f2_ready),
        .f2_pc      (f2_pc),
        .f2_instr   (f2_instr),
        .f2_predict (f2_predict),
        .f2_br_hist (f2_br_hist),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_predict  (d_predict),
        .d_br_hist  (d_br_hist),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Compare outputs against the model for the current inputs, then advance the model.
    task automatic compare_and_update();
        ent_t e;
        ent_t in_e;
        bit   ev;
        int   sz;
        in_e = '{pc: f2_pc, instr: f2_instr, pred: f2_predict, hist: f2_br_hist};
        sz   = mq.size();
        ev   = 1'b0;
        e    = '{pc: 32'h0, instr: 32'h0000_0013, pred: 1'b0, hist: 2'b00};
        if (byp_build && flush) ev = 1'b0;
        else if (sz > 0) begin ev = 1'b1; e = mq[0]; end
        else if (byp_build && f2_valid) begin ev = 1'b1; e = in_e; end
        chk("count",     {61'b0, count},     64'(sz));
        chk("f2_ready",  {63'b0, f2_ready},  {63'b0, (sz < DEPTH)});
        chk("d_valid",   {63'b0, d_valid},   {63'b0, ev});
        chk("d_pc",      {32'b0, d_pc},      {32'b0, e.pc});
        chk("d_instr",   {32'b0, d_instr},   {32'b0, e.instr});
        chk("d_predict", {63'b0, d_predict}, {63'b0, e.pred});
        chk("d_br_hist", {62'b0, d_br_hist}, {62'b0, e.hist});
        if (rst || flush) mq.delete();
        else if (byp_build && sz == 0 && f2_valid) begin
            if (!d_ready) mq.push_back(in_e);
        end else begin
            if (sz > 0 && d_ready) void'(mq.pop_front());
            if (f2_valid && sz < DEPTH) mq.push_back(in_e);
        end
    endtask

    task automatic step(input logic r, input logic fl, input logic fv, input logic dr,
                        input logic [31:0] pc);
        @(negedge clk);
        rst        = r;
        flush      = fl;
        f2_valid   = fv;
        d_ready    = dr;
        f2_pc      = pc;
        f2_instr   = $urandom;
        f2_predict = 1'($urandom);
        f2_br_hist = 2'($urandom);
        #1;
        compare_and_update();
        @(posedge clk);
    endtask

    task automatic idle_then_bubble_check(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk({tag, "_count"},   {61'b0, count},   64'd0);
        chk({tag, "_d_valid"}, {63'b0, d_valid}, 64'd0);
        chk({tag, "_d_instr"}, {32'b0, d_instr}, 64'h0000_0013);
        chk({tag, "_d_pc"},    {32'b0, d_pc},    64'd0);
    endtask

    initial begin
`ifdef FETCH_QUEUE_BYPASS_EN
        byp_build = 1'b1;
`else
        byp_build = 1'b0;
`endif
        rst = 1'b1; flush = 1'b0; f2_valid = 1'b0; d_ready = 1'b0;
        f2_pc = 32'h0; f2_instr = 32'h0; f2_predict = 1'b0; f2_br_hist = 2'b00;

        // Reset and idle
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle_then_bubble_check("reset");
        chk("reset_f2_ready", {63'b0, f2_ready}, 64'd1);

        // Fill, then a rejected fifth entry
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * i));
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h110);
        #1;
        chk("full_count",    {61'b0, count},    64'd4);
        chk("full_f2_ready", {63'b0, f2_ready}, 64'd0);
        chk("full_d_pc",     {32'b0, d_pc},     64'h100);

        // Streaming with pointer wrap
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'h110 + 32'(4 * i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Flush with concurrent enqueue/dequeue
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h300 + 32'(4 * i));
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h30C);
        idle_then_bubble_check("flush");

        // Reset mid-stream
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h400 + 32'(4 * i));
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h408);
        idle_then_bubble_check("midrst");
        chk("midrst_f2_ready", {63'b0, f2_ready}, 64'd1);

        // Empty queue, F2 presents 0x200 with Decode ready
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_count",   {61'b0, count},   64'd0);
        chk("byp_d_valid", {63'b0, d_valid}, 64'd0);
`else
        chk("nobyp_d_pc",    {32'b0, d_pc},    64'h200);
        chk("nobyp_d_valid", {63'b0, d_valid}, 64'd1);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom), 32'h1000 + 32'(4 * i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
